weight_mem_ctrl: RTL and testbench

Sequencer in front of one weight_memory instance.
- LOAD: accepts a valid/ready stream of num_weights weights and writes them at auto-incrementing addresses 0..num_weights-1.
- STREAM: sweeps read addresses 0..num_weights-1 and delivers the weights to the neuron MAC as a valid/ready stream with a last flag.
- Absorbs the memory's 1-cycle read latency with a 2-entry output buffer, so downstream backpressure never loses data.

---
 rtl/neuron_pkg.sv | 19 +
 rtl/weight_out_buf.sv | 41 ++++
 rtl/weight_mem_ctrl.sv | 157 +++++++++++++++
 tb/tb_weight_mem_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types for the neuron weight path: controller state encoding and
// output-buffer sizing.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;
  localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int BUF_IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  function automatic logic [BUF_IDX_W-1:0] buf_idx_inc(input logic [BUF_IDX_W-1:0] idx);
    return (idx == BUF_IDX_W'(BUF_DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/weight_out_buf.sv
// Small FIFO of {last, data} entries that soaks up read data the MAC is not
// ready to take yet. Only the occupancy/pointer state is reset.
module weight_out_buf
  import neuron_pkg::*;
#(
  parameter int data_bits = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [data_bits-1:0] push_data,
  input  logic                 push_last,
  input  logic                 pop,
  output logic [BUF_CNT_W-1:0] count,
  output logic [data_bits-1:0] head_data,
  output logic                 head_last
);

  logic [data_bits:0]   entry [BUF_DEPTH];
  logic [BUF_IDX_W-1:0] wr_idx;
  logic [BUF_IDX_W-1:0] rd_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= buf_idx_inc(wr_idx);
      if (pop)  rd_idx <= buf_idx_inc(rd_idx);
      count <= count + BUF_CNT_W'(push) - BUF_CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) entry[wr_idx] <= {push_last, push_data};
  end

  assign {head_last, head_data} = entry[rd_idx];

endmodule

// File: rtl/weight_mem_ctrl.sv
// Load/stream sequencer in front of a single weight_memory: writes an
// incoming weight stream, then replays it to the MAC with backpressure.
module weight_mem_ctrl
  import neuron_pkg::*;
#(
  parameter int data_bits    = 16,
  parameter int num_weights  = 784,
  parameter int address_bits = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic                    in_valid,
  input  logic [data_bits-1:0]    in_data,
  output logic                    in_ready,
  input  logic                    run_start,
  output logic                    out_valid,
  output logic [data_bits-1:0]    out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    loaded,
  output logic                    done,
  output logic                    mem_write_en,
  output logic [address_bits-1:0] mem_write_add,
  output logic [data_bits-1:0]    mem_weight_in,
  output logic                    mem_read_en,
  output logic [address_bits-1:0] mem_read_add,
  input  logic [data_bits-1:0]    mem_weight_out
);

  localparam logic [address_bits-1:0] LAST_ADDR = address_bits'(num_weights - 1);

  state_t                  state;
  state_t                  state_next;
  logic [address_bits-1:0] wr_ptr;
  logic [address_bits-1:0] rd_ptr;
  logic                    rd_done;
  logic                    vld_p1;
  logic                    last_p1;

  logic [BUF_CNT_W-1:0]    buf_count;
  logic [data_bits-1:0]    head_data;
  logic                    head_last;
  logic                    buf_empty;
  logic                    wr_fire;
  logic                    issue;
  logic                    pop;
  logic                    pop_buf;
  logic                    push_buf;
  logic                    start_run;
  logic [BUF_CNT_W:0]      occ_after;

  assign buf_empty = (buf_count == '0);
  assign wr_fire   = (state == LOAD) && in_valid;
  assign start_run = (state == IDLE) && !load_start && run_start && loaded;

  // Read data bypasses the buffer when it is empty, so the first word
  // reaches the MAC in the same cycle the memory returns it.
  assign out_valid = !buf_empty || vld_p1;
  assign out_data  = !buf_empty ? head_data : (vld_p1 ? mem_weight_out : '0);
  assign out_last  = !buf_empty ? head_last : (vld_p1 && last_p1);
  assign pop       = out_valid && out_ready;
  assign pop_buf   = pop && !buf_empty;
  assign push_buf  = vld_p1 && !(pop && buf_empty);

  // A read may only be issued if its data is guaranteed a buffer slot.
  assign occ_after = (BUF_CNT_W+1)'(buf_count) + (BUF_CNT_W+1)'(vld_p1)
                   - (BUF_CNT_W+1)'(pop);
  assign issue     = (state == STREAM) && !rd_done
                   && (occ_after < (BUF_CNT_W+1)'(BUF_DEPTH));

  assign in_ready      = (state == LOAD);
  assign busy          = (state != IDLE);
  assign mem_write_en  = wr_fire;
  assign mem_write_add = wr_fire ? wr_ptr : '0;
  assign mem_weight_in = wr_fire ? in_data : '0;
  assign mem_read_en   = issue;
  assign mem_read_add  = issue ? rd_ptr : '0;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (load_start)                state_next = LOAD;
        else if (run_start && loaded)  state_next = STREAM;
      end
      LOAD: begin
        if (wr_fire && (wr_ptr == LAST_ADDR)) state_next = IDLE;
      end
      STREAM: begin
        if (pop && out_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_done <= 1'b0;
      loaded  <= 1'b0;
      done    <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      state  <= state_next;
      done   <= (state == STREAM) && pop && out_last;
      vld_p1 <= issue;

      if ((state == IDLE) && load_start) begin
        wr_ptr <= '0;
        loaded <= 1'b0;
      end else if (wr_fire) begin
        if (wr_ptr == LAST_ADDR) begin
          wr_ptr <= '0;
          loaded <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end

      if (start_run) begin
        rd_ptr  <= '0;
        rd_done <= 1'b0;
      end else if (issue) begin
        if (rd_ptr == LAST_ADDR) begin
          rd_ptr  <= '0;
          rd_done <= 1'b1;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  // ---- stage p1: memory read latency, last tag travels with the read ----
  always_ff @(posedge clk) begin
    last_p1 <= issue && (rd_ptr == LAST_ADDR);
  end

  weight_out_buf #(
    .data_bits (data_bits)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push_buf),
    .push_data (mem_weight_out),
    .push_last (last_p1),
    .pop       (pop_buf),
    .count     (buf_count),
    .head_data (head_data),
    .head_last (head_last)
  );

endmodule

// File: tb/tb_weight_mem_ctrl.sv
// Directed bench for weight_mem_ctrl with a behavioural 1-cycle weight memory.
module tb_weight_mem_ctrl;

  localparam int DW = 16;
  localparam int NW = 784;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start, in_valid, run_start, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, out_last, busy, loaded, done;
  logic [DW-1:0] out_data, mem_weight_in, mem_weight_out;
  logic          mem_write_en, mem_read_en;
  logic [AW-1:0] mem_write_add, mem_read_add;

  always #5 clk = ~clk;

  weight_mem_ctrl #(.data_bits(DW), .num_weights(NW), .address_bits(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .load_start     (load_start),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .run_start      (run_start),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .busy           (busy),
    .loaded         (loaded),
    .done           (done),
    .mem_write_en   (mem_write_en),
    .mem_write_add  (mem_write_add),
    .mem_weight_in  (mem_weight_in),
    .mem_read_en    (mem_read_en),
    .mem_read_add   (mem_read_add),
    .mem_weight_out (mem_weight_out)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_write_add] <= mem_weight_in;
    if (mem_read_en)  mem_weight_out <= mem[mem_read_add];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] wval(input int i);
    return DW'(i) ^ 16'hA5A5;
  endfunction

  typedef struct {
    logic          ls, rs, iv;
    logic [DW-1:0] din;
    logic          e_rdy, e_wen;
    logic [AW-1:0] e_wadd;
    logic [DW-1:0] e_wdata;
    logic          e_ren, e_busy_next;
  } vec_t;

  function automatic vec_t mk(input logic ls, input logic rs, input logic iv,
                              input logic [DW-1:0] din, input logic rdy, input logic wen,
                              input logic [AW-1:0] wadd, input logic [DW-1:0] wdata,
                              input logic ren, input logic bn);
    vec_t v;
    v.ls = ls; v.rs = rs; v.iv = iv; v.din = din;
    v.e_rdy = rdy; v.e_wen = wen; v.e_wadd = wadd; v.e_wdata = wdata;
    v.e_ren = ren; v.e_busy_next = bn;
    return v;
  endfunction

  task automatic idle_inputs();
    load_start = 1'b0; run_start = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
  endtask

  task automatic load_words(input int n, input string tag);
    int errs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = wval(i);
      #1;
      if (!(in_ready && mem_write_en && mem_write_add == AW'(i) &&
            mem_weight_in == wval(i) && !loaded)) errs++;
    end
    check({tag, "_writes"}, errs, 0);
  endtask

  task automatic full_load(input string tag);
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1 load_start = 1'b0;
    load_words(NW, tag);
    @(negedge clk);
    #1;
    check({tag, "_loaded"}, loaded, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_no_write_idle"}, mem_write_en, 0);
    in_valid = 1'b0;
  endtask

  task automatic run_stream(input int mode, input bit poke_load, input string tag);
    int idx = 0, cyc = 0, first_valid = -1, last_cyc = -1;
    int data_err = 0, last_err = 0, stall_err = 0, addr_err = 0, wr_cnt = 0, done_cnt = 0;
    logic          stalled = 1'b0;
    logic [DW-1:0] held = '0;
    while (idx < NW && cyc < 6000) begin
      @(negedge clk);
      run_start  = (cyc == 0);
      load_start = poke_load && (cyc == 20);
      out_ready  = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      #1;
      if (mem_read_en && mem_read_add >= AW'(NW)) addr_err++;
      if (mem_write_en) wr_cnt++;
      if (done) done_cnt++;
      if (stalled && (!out_valid || out_data !== held)) stall_err++;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        if (out_data !== wval(idx)) data_err++;
        if (out_last !== (idx == NW - 1)) last_err++;
        if (idx == NW - 1) last_cyc = cyc;
        idx++;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      cyc++;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle_inputs();
      out_ready = 1'b1;
      #1;
      if (done) done_cnt++;
      if (k == 0) begin
        check({tag, "_done_pulse"}, done, 1);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_no_extra_word"}, out_valid, 0);
      end
    end
    check({tag, "_words"}, idx, NW);
    check({tag, "_first_valid_lat"}, first_valid, 2);
    check({tag, "_data_err"}, data_err, 0);
    check({tag, "_last_err"}, last_err, 0);
    check({tag, "_stall_err"}, stall_err, 0);
    check({tag, "_addr_range_err"}, addr_err, 0);
    check({tag, "_writes_in_stream"}, wr_cnt, 0);
    check({tag, "_done_count"}, done_cnt, 1);
    if (mode == 0) check({tag, "_throughput"}, last_cyc, NW + 1);
  endtask

  vec_t tbl [8];

  initial begin
    tbl[0] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b0, 1'b0);
    tbl[1] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b0, 1'b0);
    tbl[2] = mk(1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b0, 1'b0);
    tbl[3] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b0, 1'b1);
    tbl[4] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 10'd0, 16'h0000, 1'b0, 1'b1);
    tbl[5] = mk(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 10'd0, 16'h1234, 1'b0, 1'b1);
    tbl[6] = mk(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b1, 10'd1, 16'hBEEF, 1'b0, 1'b1);
    tbl[7] = mk(1'b1, 1'b0, 1'b1, 16'h0F0F, 1'b1, 1'b1, 10'd2, 16'h0F0F, 1'b0, 1'b1);

    reset = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_loaded", loaded, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_done", done, 0);
    check("rst_mem_read_en", mem_read_en, 0);
    check("rst_mem_write_en", mem_write_en, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      load_start = tbl[i].ls;
      run_start  = tbl[i].rs;
      in_valid   = tbl[i].iv;
      in_data    = tbl[i].din;
      #1;
      check($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      check($sformatf("vec%0d_wen", i), mem_write_en, tbl[i].e_wen);
      check($sformatf("vec%0d_wadd", i), mem_write_add, tbl[i].e_wadd);
      check($sformatf("vec%0d_wdata", i), mem_weight_in, tbl[i].e_wdata);
      check($sformatf("vec%0d_ren", i), mem_read_en, tbl[i].e_ren);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_busy_next", i), busy, tbl[i].e_busy_next);
    end

    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_rst_in_ready", in_ready, 0);
    check("async_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();

    begin
      int ren_cnt = 0, busy_cnt = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        run_start = 1'b1;
        #1;
        if (mem_read_en) ren_cnt++;
        if (busy) busy_cnt++;
      end
      run_start = 1'b0;
      check("unloaded_run_reads", ren_cnt, 0);
      check("unloaded_run_busy", busy_cnt, 0);
    end

    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1 load_start = 1'b0;
    load_words(300, "partial");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midload_rst_in_ready", in_ready, 0);
    check("midload_rst_wen", mem_write_en, 0);
    check("midload_rst_wadd", mem_write_add, 0);
    check("midload_rst_busy", busy, 0);
    check("midload_rst_loaded", loaded, 0);
    check("midload_rst_out_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();

    full_load("load1");
    run_stream(0, 1'b0, "s1");
    run_stream(1, 1'b1, "s2");
    run_stream(0, 1'b0, "s3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
